// File: rtl/ledr_pkg.sv
// ledr_pkg: register map, FSM states and STATUS layout shared by the LEDR controller.
package ledr_pkg;

    // Register word indices, i.e. byte offset within the window divided by 4.
    localparam logic [2:0] OFF_OUT    = 3'd0;
    localparam logic [2:0] OFF_MASK   = 3'd1;
    localparam logic [2:0] OFF_PERIOD = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_SET    = 3'd4;
    localparam logic [2:0] OFF_CLR    = 3'd5;
    localparam logic [2:0] OFF_TGL    = 3'd6;

    localparam int STAT_PHASE_BIT = 0;
    localparam int STAT_CNT_LSB   = 16;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_e;

    // Expands the four byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strobe_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

endpackage

// File: rtl/blink_timer.sv
// blink_timer: half-period counter producing the blink phase and a wrapping toggle count.
module blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clr,
    output logic                phase,
    output logic [15:0]         toggle_cnt
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [15:0]         tcnt_q, tcnt_d;
    logic                wrap;

    assign wrap       = cnt_q == period - PERIOD_W'(1);
    assign phase      = phase_q;
    assign toggle_cnt = tcnt_q;

    // A period rewrite or a zero period parks the timer; otherwise count and flip on wrap.
    always_comb begin
        cnt_d   = cnt_q + PERIOD_W'(1);
        phase_d = phase_q;
        tcnt_d  = tcnt_q;
        if (clr || period == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (wrap) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
            tcnt_d  = tcnt_q + 16'd1;
        end
    end

    // Timer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule

// File: rtl/mmio_ledr_ctrl.sv
// mmio_ledr_ctrl: picorv32-bus LED controller with readback and blink; LEDR_SETCLR_EN adds SET/CLR/TGL aliases.
module mmio_ledr_ctrl
    import ledr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          NUM_LEDS  = 10,
    parameter int          PERIOD_W  = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_valid,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wstrb,
    output logic                mem_ready,
    output logic [31:0]         mem_rdata,
    output logic [NUM_LEDS-1:0] ledr
);

    state_e              state_q, state_d;
    logic [NUM_LEDS-1:0] out_q, out_d;
    logic [NUM_LEDS-1:0] mask_q, mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [NUM_LEDS-1:0] ledr_q, ledr_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                hit, acc, wr, period_clr, phase;
    logic [2:0]          idx;
    logic [31:0]         bm, wd, rd_val;
    logic [15:0]         toggle_cnt;
    logic                unused_addr;

    assign hit         = mem_valid && mem_addr[31:5] == BASE_ADDR[31:5];
    assign acc         = hit && state_q == ST_IDLE;
    assign wr          = acc && mem_wstrb != 4'd0;
    assign idx         = mem_addr[4:2];
    assign bm          = strobe_mask(mem_wstrb);
    assign wd          = mem_wdata & bm;
    assign period_clr  = wr && idx == OFF_PERIOD;
    assign unused_addr = &{1'b0, mem_addr[1:0]};

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign ledr      = ledr_q;

    blink_timer #(
        .PERIOD_W(PERIOD_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .period    (period_q),
        .clr       (period_clr),
        .phase     (phase),
        .toggle_cnt(toggle_cnt)
    );

    // Byte-strobed register writes; undecoded offsets fall through untouched.
    always_comb begin
        out_d    = out_q;
        mask_d   = mask_q;
        period_d = period_q;
        if (wr) begin
            case (idx)
                OFF_OUT:    out_d    = NUM_LEDS'((32'(out_q) & ~bm) | wd);
                OFF_MASK:   mask_d   = NUM_LEDS'((32'(mask_q) & ~bm) | wd);
                OFF_PERIOD: period_d = PERIOD_W'((32'(period_q) & ~bm) | wd);
`ifdef LEDR_SETCLR_EN
                OFF_SET:    out_d    = out_q | NUM_LEDS'(wd);
                OFF_CLR:    out_d    = out_q & ~NUM_LEDS'(wd);
                OFF_TGL:    out_d    = out_q ^ NUM_LEDS'(wd);
`endif
                default:    ;
            endcase
        end
    end

    // Readback mux; aliases and reserved offsets read as zero.
    always_comb begin
        rd_val = '0;
        case (idx)
            OFF_OUT:    rd_val = 32'(out_q);
            OFF_MASK:   rd_val = 32'(mask_q);
            OFF_PERIOD: rd_val = 32'(period_q);
            OFF_STATUS: begin
                rd_val[STAT_PHASE_BIT]       = phase;
                rd_val[STAT_CNT_LSB +: 16]   = toggle_cnt;
            end
            default:    ;
        endcase
    end

    // Two-state bus handshake: accept in IDLE, spend one RESP cycle, never accept back to back.
    always_comb begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
        rdata_d = '0;
        if (acc) begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            rdata_d = rd_val;
        end
    end

    // LED drive is registered so it trails register and phase changes by one cycle.
    always_comb begin
        ledr_d = out_q ^ (mask_q & {NUM_LEDS{phase}});
    end

    // Register file, handshake and LED output state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            mask_q   <= '0;
            period_q <= '0;
            ledr_q   <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            ledr_q   <= ledr_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mmio_ledr_ctrl.sv
// tb_mmio_ledr_ctrl: directed bench with a per-cycle reference model of the LED controller.
module tb_mmio_ledr_ctrl;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] LEDM = 32'h0000_03FF;
    localparam logic [31:0] PERM = 32'h00FF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [9:0]  ledr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mmio_ledr_ctrl #(
        .BASE_ADDR(BASE),
        .NUM_LEDS (10),
        .PERIOD_W (24)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .ledr     (ledr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: registers as plain words; blink state derived from cycles since the last period write.
    logic [31:0] m_out = '0, m_mask = '0, m_p = '0;
    int          m_k = 0;
    logic [15:0] m_tb = '0;
    bit          m_busy = 1'b0;
    logic        e_ready = 1'b0;
    logic [31:0] e_rdata = '0, e_ledr = '0;
    logic        ph;
    logic [15:0] tg;
    logic [31:0] bmask, wdm;
    logic [4:0]  off;
    bit          pw;

    always @(posedge clk) begin
        ph = (m_p != 0) && ((m_k / int'(m_p)) % 2 == 1);
        tg = m_tb + ((m_p != 0) ? 16'(m_k / int'(m_p)) : 16'd0);
        if (reset) begin
            m_out = '0; m_mask = '0; m_p = '0; m_k = 0; m_tb = '0;
            m_busy = 1'b0; e_ready = 1'b0; e_rdata = '0; e_ledr = '0;
        end else begin
            e_ledr = m_out ^ (m_mask & (ph ? LEDM : 32'd0));
            pw = 1'b0;
            off = {mem_addr[4:2], 2'b00};
            if (m_busy) begin
                m_busy = 1'b0; e_ready = 1'b0; e_rdata = '0;
            end else if (mem_valid && mem_addr[31:5] == BASE[31:5]) begin
                m_busy = 1'b1;
                e_ready = 1'b1;
                case (off)
                    5'h00: e_rdata = m_out;
                    5'h04: e_rdata = m_mask;
                    5'h08: e_rdata = m_p;
                    5'h0C: e_rdata = {tg, 15'd0, ph};
                    default: e_rdata = '0;
                endcase
                bmask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
                wdm = mem_wdata & bmask;
                if (mem_wstrb != 0) begin
                    case (off)
                        5'h00: m_out = ((m_out & ~bmask) | wdm) & LEDM;
                        5'h04: m_mask = ((m_mask & ~bmask) | wdm) & LEDM;
                        5'h08: begin m_p = ((m_p & ~bmask) | wdm) & PERM; pw = 1'b1; end
`ifdef LEDR_SETCLR_EN
                        5'h10: m_out = (m_out | wdm) & LEDM;
                        5'h14: m_out = m_out & ~wdm;
                        5'h18: m_out = (m_out ^ wdm) & LEDM;
`endif
                        default: ;
                    endcase
                end
            end else begin
                e_ready = 1'b0; e_rdata = '0;
            end
            if (pw) begin
                m_tb = tg; m_k = 0;
            end else m_k++;
        end
    end

    // Every cycle: outputs must match the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", {31'd0, mem_ready}, {31'd0, e_ready});
            chk("cyc_rdata", mem_rdata, e_rdata);
            chk("cyc_ledr", 32'(ledr), e_ledr);
        end
    end

    task automatic bus(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input bit exp_ack, output logic [31:0] rd, output int lat);
        bit got = 1'b0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        rd = '0; lat = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin got = 1'b1; lat = i; rd = mem_rdata; end
        end
        @(negedge clk);
        mem_valid = 1'b0; mem_wstrb = '0;
        chk(nm, {31'd0, got}, {31'd0, exp_ack});
    endtask

    task automatic wait_ledr(input logic [9:0] v, output int n);
        n = 0;
        while (ledr !== v && n < 40) begin
            @(posedge clk); #1; n++;
        end
    endtask

    logic [31:0] rd, s1, s2;
    logic [9:0]  v1, v2;
    int          lat, n, bad;

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        chk("rst_ledr", 32'(ledr), 32'd0);
        chk("rst_ready", {31'd0, mem_ready}, 32'd0);
        @(negedge clk) reset = 1'b0;

        bus("rd0_ack", BASE, 0, 4'h0, 1'b1, rd, lat);
        chk("rd0_lat", lat, 1);
        chk("rd0_data", rd, 32'd0);

        bus("wr_out_ack", BASE, 32'h3FF, 4'h1, 1'b1, rd, lat);
        bus("rd_out_ack", BASE, 0, 4'h0, 1'b1, rd, lat);
        chk("out_bytewr", rd, 32'h0FF);
        chk("ledr_0ff", 32'(ledr), 32'h0FF);

        bus("wr_out", BASE, 32'h001, 4'hF, 1'b1, rd, lat);
        bus("wr_mask", BASE + 4, 32'h300, 4'hF, 1'b1, rd, lat);
        bus("wr_per", BASE + 8, 32'd4, 4'hF, 1'b1, rd, lat);
        v1 = ledr;
        n = 0;
        while (ledr === v1 && n < 20) begin @(posedge clk); #1; n++; end
        v1 = ledr;
        n = 0;
        while (ledr === v1 && n < 20) begin @(posedge clk); #1; n++; end
        v2 = ledr;
        chk("blink_half", n, 4);
        chk("blink_xor", 32'(v1 ^ v2), 32'h300);

        bus("st1_ack", BASE + 12, 0, 4'h0, 1'b1, s1, lat);
        repeat (6) @(negedge clk);
        bus("st2_ack", BASE + 12, 0, 4'h0, 1'b1, s2, lat);
        chk("tgl_delta", 32'(16'(s2[31:16] - s1[31:16])), 32'd2);
        chk("tgl_phase", {31'd0, s2[0]}, {31'd0, s1[0]});

        wait_ledr(10'h001, n);
        wait_ledr(10'h301, n);
        chk("ph1_seen", 32'(ledr), 32'h301);
        bus("rewr_per", BASE + 8, 32'd4, 4'hF, 1'b1, rd, lat);
        @(posedge clk); #1;
        chk("pw_clear", 32'(ledr), 32'h001);
        wait_ledr(10'h301, n);
        chk("pw_next", n, 4);

        bus("per0", BASE + 8, 32'd0, 4'hF, 1'b1, rd, lat);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ledr !== 10'h001) bad++;
        end
        chk("per0_steady", bad, 0);

        bus("nohit", BASE + 32'h20, 0, 4'h0, 1'b0, rd, lat);
        bus("rsv_ack", BASE + 32'h1C, 0, 4'h0, 1'b1, rd, lat);
        chk("rsv_rd", rd, 32'd0);

        bus("out_f0", BASE, 32'h0F0, 4'hF, 1'b1, rd, lat);
        bus("set", BASE + 32'h10, 32'h003, 4'hF, 1'b1, rd, lat);
        bus("rd_set", BASE, 0, 4'h0, 1'b1, rd, lat);
`ifdef LEDR_SETCLR_EN
        chk("set_val", rd, 32'h0F3);
`else
        chk("set_val", rd, 32'h0F0);
`endif
        bus("clr", BASE + 32'h14, 32'h030, 4'hF, 1'b1, rd, lat);
        bus("rd_clr", BASE, 0, 4'h0, 1'b1, rd, lat);
`ifdef LEDR_SETCLR_EN
        chk("clr_val", rd, 32'h0C3);
`else
        chk("clr_val", rd, 32'h0F0);
`endif
        bus("tgl", BASE + 32'h18, 32'h3FF, 4'hF, 1'b1, rd, lat);
        bus("rd_tgl", BASE, 0, 4'h0, 1'b1, rd, lat);
`ifdef LEDR_SETCLR_EN
        chk("tgl_val", rd, 32'h33C);
`else
        chk("tgl_val", rd, 32'h0F0);
`endif
        bus("rd_alias", BASE + 32'h10, 0, 4'h0, 1'b1, rd, lat);
        chk("alias_rd0", rd, 32'd0);

        bus("per_b1", BASE + 8, 32'hAB12_34CD, 4'h2, 1'b1, rd, lat);
        bus("rd_per", BASE + 8, 0, 4'h0, 1'b1, rd, lat);
        chk("per_bytewr", rd, 32'h0000_3400);

        @(negedge clk);
        mem_valid = 1'b1; mem_addr = BASE; mem_wstrb = 4'h0; reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_drop", {31'd0, mem_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_valid = 1'b0;
        bus("post_rst", BASE, 0, 4'h0, 1'b1, rd, lat);
        chk("post_rst_out", rd, 32'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
